// File: rtl/shot_manager_pkg.sv
// Shared entity record layout, scan FSM encoding and heading step table
// for ship shots and, later, asteroid motion.
package asteroids_pkg;

  localparam int ENTITY_SIZE = 34;

  localparam int DIR_LSB  = 0;
  localparam int DIR_W    = 6;
  localparam int X_LSB    = 6;
  localparam int Y_LSB    = 16;
  localparam int POS_W    = 10;
  localparam int ACT_BIT  = 26;
  localparam int LIFE_LSB = 27;
  localparam int LIFE_W   = 7;

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'd0,
    FSM_SPAWN  = 2'd1,
    FSM_UPDATE = 2'd2
  } shot_fsm_e;

  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } step_t;

  // 16 headings, clockwise from straight up (screen y grows downward).
  function automatic step_t step_lookup(input logic [3:0] sector);
    step_t s;
    case (sector)
      4'd0:    s = {3'sd0, -3'sd2};
      4'd1:    s = {3'sd1, -3'sd2};
      4'd2:    s = {3'sd1, -3'sd1};
      4'd3:    s = {3'sd2, -3'sd1};
      4'd4:    s = {3'sd2, 3'sd0};
      4'd5:    s = {3'sd2, 3'sd1};
      4'd6:    s = {3'sd1, 3'sd1};
      4'd7:    s = {3'sd1, 3'sd2};
      4'd8:    s = {3'sd0, 3'sd2};
      4'd9:    s = {-3'sd1, 3'sd2};
      4'd10:   s = {-3'sd1, 3'sd1};
      4'd11:   s = {-3'sd2, 3'sd1};
      4'd12:   s = {-3'sd2, 3'sd0};
      4'd13:   s = {-3'sd2, -3'sd1};
      4'd14:   s = {-3'sd1, -3'sd1};
      default: s = {-3'sd1, -3'sd2};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/shot_manager_if.sv
// Control/data bundle between the game controller and shot_manager.
interface shot_manager_if #(
  parameter int MAX_SHOTS   = 10,
  parameter int ENTITY_SIZE = asteroids_pkg::ENTITY_SIZE
);
  logic                             move_tick;
  logic                             fire;
  logic [5:0]                       ship_dir;
  logic [9:0]                       ship_x;
  logic [9:0]                       ship_y;
  logic                             hit_valid;
  logic [3:0]                       hit_idx;
  logic [MAX_SHOTS*ENTITY_SIZE-1:0] shots_out;
  logic [3:0]                       active_count;
  logic                             fire_drop;
  logic                             busy;

  modport master (
    output move_tick, fire, ship_dir, ship_x, ship_y, hit_valid, hit_idx,
    input  shots_out, active_count, fire_drop, busy
  );

  modport slave (
    input  move_tick, fire, ship_dir, ship_x, ship_y, hit_valid, hit_idx,
    output shots_out, active_count, fire_drop, busy
  );
endinterface

// File: rtl/shot_manager_step.sv
// Heading decoder: maps the heading sector (dir[5:2]) to a signed per-tick step.
module shot_step
  import asteroids_pkg::*;
(
  input  logic [3:0]        i_dir_sector,
  output logic signed [2:0] o_dx,
  output logic signed [2:0] o_dy
);
  step_t w_step;

  assign w_step = step_lookup(i_dir_sector);
  assign o_dx   = w_step.dx;
  assign o_dy   = w_step.dy;
endmodule

// File: rtl/shot_manager.sv
// Shot slot manager: spawns ship shots into free slots, advances them on
// move_tick and clears them on hits, visiting one slot per clock.
//
// state  | meaning
// IDLE   | waiting for move_tick or a pending spawn
// SPAWN  | scanning for the first free slot
// UPDATE | moving and ageing every active slot
module shot_manager #(
  parameter int ENTITY_SIZE = asteroids_pkg::ENTITY_SIZE,
  parameter int MAX_SHOTS   = 10,
  parameter int SHOT_LIFE   = 60,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240
) (
  input logic           clk,
  input logic           reset_n,
  shot_manager_if.slave bus
);
  import asteroids_pkg::*;

  localparam logic [1:0]         ST_IDLE   = FSM_IDLE;
  localparam logic [1:0]         ST_SPAWN  = FSM_SPAWN;
  localparam logic [1:0]         ST_UPDATE = FSM_UPDATE;
  localparam logic [3:0]         LAST_IDX  = 4'(MAX_SHOTS - 1);
  localparam logic [3:0]         N_SLOTS   = 4'(MAX_SHOTS);
  localparam logic [6:0]         LIFE_INIT = 7'(SHOT_LIFE);
  localparam logic signed [10:0] W_S       = 11'(SCREEN_W);
  localparam logic signed [10:0] H_S       = 11'(SCREEN_H);

  logic [ENTITY_SIZE-1:0] r_slots [MAX_SHOTS];
  logic [1:0]             r_state;
  logic [3:0]             r_idx;
  logic                   r_pending;
  logic                   r_fire_q;
  logic                   r_drop;
  logic [3:0]             r_count;
  logic [5:0]             r_lat_dir;
  logic [9:0]             r_lat_x;
  logic [9:0]             r_lat_y;

  logic [ENTITY_SIZE-1:0] w_cur;
  logic [ENTITY_SIZE-1:0] w_upd;
  logic [ENTITY_SIZE-1:0] w_new;
  logic                   w_fire_edge;
  logic                   w_hit_ok;
  logic                   w_hit_cur;
  logic                   w_cur_free;
  logic                   w_last;
  logic signed [2:0]      w_dx;
  logic signed [2:0]      w_dy;
  logic signed [10:0]     w_x_sum;
  logic signed [10:0]     w_y_sum;
  logic [9:0]             w_x_new;
  logic [9:0]             w_y_new;
  logic [6:0]             w_life;
  logic [3:0]             w_pop;

  assign w_cur       = r_slots[r_idx];
  assign w_life      = w_cur[LIFE_LSB +: LIFE_W];
  assign w_last      = (r_idx == LAST_IDX);
  assign w_fire_edge = bus.fire & ~r_fire_q;
  assign w_hit_ok    = bus.hit_valid && (bus.hit_idx < N_SLOTS);
  assign w_hit_cur   = w_hit_ok && (bus.hit_idx == r_idx);
  // A slot being killed this cycle is not yet free for a spawn.
  assign w_cur_free  = !w_cur[ACT_BIT] && !w_hit_cur;

  shot_step u_step (
    .i_dir_sector (w_cur[DIR_LSB+2 +: 4]),
    .o_dx         (w_dx),
    .o_dy         (w_dy)
  );

  assign w_x_sum = $signed({1'b0, w_cur[X_LSB +: POS_W]}) + {{8{w_dx[2]}}, w_dx};
  assign w_y_sum = $signed({1'b0, w_cur[Y_LSB +: POS_W]}) + {{8{w_dy[2]}}, w_dy};

  always_comb begin
    w_x_new = w_x_sum[9:0];
    if (w_x_sum[10])
      w_x_new = 10'(w_x_sum + W_S);
    else if (w_x_sum >= W_S)
      w_x_new = 10'(w_x_sum - W_S);
  end

  always_comb begin
    w_y_new = w_y_sum[9:0];
    if (w_y_sum[10])
      w_y_new = 10'(w_y_sum + H_S);
    else if (w_y_sum >= H_S)
      w_y_new = 10'(w_y_sum - H_S);
  end

  // A shot whose life would reach zero is retired as an all-zero record.
  always_comb begin
    w_upd = '0;
    if (w_life > 7'd1) begin
      w_upd[DIR_LSB +: DIR_W]   = w_cur[DIR_LSB +: DIR_W];
      w_upd[X_LSB +: POS_W]     = w_x_new;
      w_upd[Y_LSB +: POS_W]     = w_y_new;
      w_upd[ACT_BIT]            = 1'b1;
      w_upd[LIFE_LSB +: LIFE_W] = w_life - 7'd1;
    end
  end

  always_comb begin
    w_new                     = '0;
    w_new[DIR_LSB +: DIR_W]   = r_lat_dir;
    w_new[X_LSB +: POS_W]     = r_lat_x;
    w_new[Y_LSB +: POS_W]     = r_lat_y;
    w_new[ACT_BIT]            = 1'b1;
    w_new[LIFE_LSB +: LIFE_W] = LIFE_INIT;
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < MAX_SHOTS; i++)
      w_pop = w_pop + {3'b000, r_slots[i][ACT_BIT]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_SHOTS; i++)
        r_slots[i] <= '0;
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_fire_q  <= 1'b0;
      r_drop    <= 1'b0;
      r_count   <= '0;
      r_lat_dir <= '0;
      r_lat_x   <= '0;
      r_lat_y   <= '0;
    end else begin
      r_fire_q <= bus.fire;
      r_count  <= w_pop;
      r_drop   <= 1'b0;

      if (w_fire_edge) begin
        if (r_pending) begin
          r_drop <= 1'b1;
        end else begin
          r_pending <= 1'b1;
          r_lat_dir <= bus.ship_dir;
          r_lat_x   <= bus.ship_x;
          r_lat_y   <= bus.ship_y;
        end
      end

      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          if (bus.move_tick)
            r_state <= ST_UPDATE;
          else if (r_pending)
            r_state <= ST_SPAWN;
        end
        ST_SPAWN: begin
          if (w_cur_free) begin
            r_slots[r_idx] <= w_new;
            r_pending      <= 1'b0;
            r_state        <= ST_IDLE;
          end else if (w_last) begin
            r_drop    <= 1'b1;
            r_pending <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        ST_UPDATE: begin
          if (w_cur[ACT_BIT])
            r_slots[r_idx] <= w_upd;
          if (w_last)
            r_state <= ST_IDLE;
          else
            r_idx <= r_idx + 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Last assignment wins: a hit overrides any scan write to the same slot.
      if (w_hit_ok)
        r_slots[bus.hit_idx] <= '0;
    end
  end

  for (genvar g = 0; g < MAX_SHOTS; g++) begin : g_out
    assign bus.shots_out[g*ENTITY_SIZE +: ENTITY_SIZE] = r_slots[g];
  end

  assign bus.active_count = r_count;
  assign bus.fire_drop    = r_drop;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule
